pc_sequencer: RTL and testbench

Program-counter sequencer for the 16-bit core. Holds the fetch PC and advances it each cycle. It redirects the PC to the branch target when the branch comparator reports a taken branch, then drives a fixed number of flush cycles to squash wrong-path instructions. It also handles stall, halt and resume from the control unit.

---
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch program-counter sequencer. Advances the PC, redirects on
//            taken branches followed by a fixed run of flush cycles, and
//            supports stall, halt and resume.
//            Optional macro PC_SEQ_BRANCH_STATS_EN builds a saturating
//            taken-redirect counter on branch_count_po (tied to zero otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int unsigned                PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0]        RESET_PC     = '0,
  parameter int unsigned                FLUSH_CYCLES = 2,
  parameter int unsigned                PC_STEP      = 1
) (
  input  logic                clk_pi,
  input  logic                reset_pi,
  input  logic                stall_pi,
  input  logic                halt_pi,
  input  logic                resume_pi,
  input  logic                is_branch_taken_pi,
  input  logic [PC_WIDTH-1:0] branch_target_pi,
  output logic [PC_WIDTH-1:0] pc_po,
  output logic                fetch_valid_po,
  output logic                flush_po,
  output logic                halted_po,
  output logic [15:0]         branch_count_po
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // The counter holds "flush cycles still to go after this one", so the load
  // value is one less than the number of bubble cycles.
  localparam logic [2:0]          c_flush_load = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;
  localparam logic [PC_WIDTH-1:0] c_pc_step    = PC_WIDTH'(PC_STEP);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;

  // State, PC and flush counter registers; reset overrides everything.
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: branch beats halt beats stall while running.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (is_branch_taken_pi) begin
          w_pc_nxt = branch_target_pi;
          if (FLUSH_CYCLES > 0) begin
            w_cnt_nxt   = c_flush_load;
            w_state_nxt = ST_FLUSH;
          end
        end else if (halt_pi) begin
          w_state_nxt = ST_HALT;
        end else if (!stall_pi) begin
          w_pc_nxt = r_pc + c_pc_step;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      ST_HALT: begin
        if (resume_pi) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Status outputs decode from state and are forced low during reset.
  always_comb begin
    pc_po          = r_pc;
    fetch_valid_po = (r_state == ST_RUN)   && !stall_pi && !reset_pi;
    flush_po       = (r_state == ST_FLUSH) && !reset_pi;
    halted_po      = (r_state == ST_HALT)  && !reset_pi;
  end

`ifdef PC_SEQ_BRANCH_STATS_EN
  logic [15:0] r_branch_count;
  logic        w_redirect;

  assign w_redirect = (r_state == ST_RUN) && is_branch_taken_pi;

  // Saturating count of redirects accepted while running.
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      r_branch_count <= 16'h0000;
    end else if (w_redirect && (r_branch_count != 16'hFFFF)) begin
      r_branch_count <= r_branch_count + 16'h0001;
    end
  end

  assign branch_count_po = r_branch_count;
`else
  assign branch_count_po = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Scoreboard bench for pc_sequencer: directed scenarios followed by
//            random traffic, checked against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int unsigned   c_flush_cycles = 2;
  localparam logic [15:0]   c_reset_pc     = 16'h0000;

  logic        clk_pi = 1'b0;
  logic        reset_pi = 1'b1;
  logic        stall_pi = 1'b0;
  logic        halt_pi = 1'b0;
  logic        resume_pi = 1'b0;
  logic        is_branch_taken_pi = 1'b0;
  logic [15:0] branch_target_pi = 16'h0000;
  logic [15:0] pc_po;
  logic        fetch_valid_po;
  logic        flush_po;
  logic        halted_po;
  logic [15:0] branch_count_po;

  pc_sequencer #(
    .PC_WIDTH     (16),
    .RESET_PC     (c_reset_pc),
    .FLUSH_CYCLES (c_flush_cycles),
    .PC_STEP      (1)
  ) dut (
    .clk_pi             (clk_pi),
    .reset_pi           (reset_pi),
    .stall_pi           (stall_pi),
    .halt_pi            (halt_pi),
    .resume_pi          (resume_pi),
    .is_branch_taken_pi (is_branch_taken_pi),
    .branch_target_pi   (branch_target_pi),
    .pc_po              (pc_po),
    .fetch_valid_po     (fetch_valid_po),
    .flush_po           (flush_po),
    .halted_po          (halted_po),
    .branch_count_po    (branch_count_po)
  );

  always #5 clk_pi = ~clk_pi;

  typedef struct packed {
    logic [15:0] pc;
    logic        valid;
    logic        flush;
    logic        halted;
    logic [15:0] count;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model state: the machine is described by how many bubble
  // cycles remain and whether the core is parked, not by an encoded state.
  int unsigned m_pc         = c_reset_pc;
  int          m_flush_left = 0;
  bit          m_halted     = 1'b0;
  int unsigned m_count      = 0;

  function automatic void check1(string name, logic [15:0] got, logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Monitor: every cycle the DUT presents outputs; compare against the
  // oldest pending expectation away from the active edge.
  always @(negedge clk_pi) begin
    if (q_exp.size() > 0) begin
      exp_t e;
      e = q_exp.pop_front();
      check1("pc",          pc_po,                    e.pc);
      check1("fetch_valid", {15'd0, fetch_valid_po},  {15'd0, e.valid});
      check1("flush",       {15'd0, flush_po},        {15'd0, e.flush});
      check1("halted",      {15'd0, halted_po},       {15'd0, e.halted});
      check1("branch_count", branch_count_po,         e.count);
    end
  end

  // Apply one cycle of inputs, record what the DUT must show in this cycle,
  // then advance the model across the coming clock edge.
  task automatic cycle(input bit rst, input bit stall, input bit halt,
                       input bit resume, input bit br, input logic [15:0] tgt);
    exp_t e;
    @(posedge clk_pi);
    #1;
    reset_pi           = rst;
    stall_pi           = stall;
    halt_pi            = halt;
    resume_pi          = resume;
    is_branch_taken_pi = br;
    branch_target_pi   = tgt;

    e.pc     = m_pc[15:0];
    e.valid  = !rst && !m_halted && (m_flush_left == 0) && !stall;
    e.flush  = !rst && (m_flush_left > 0);
    e.halted = !rst && m_halted;
    e.count  = m_count[15:0];
    q_exp.push_back(e);

    if (rst) begin
      m_pc = c_reset_pc; m_flush_left = 0; m_halted = 1'b0; m_count = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_halted) begin
      if (resume) m_halted = 1'b0;
    end else if (br) begin
      m_pc = tgt;
      m_flush_left = c_flush_cycles;
`ifdef PC_SEQ_BRANCH_STATS_EN
      if (m_count < 65535) m_count++;
`endif
    end else if (halt) begin
      m_halted = 1'b1;
    end else if (!stall) begin
      m_pc = (m_pc + 1) % 65536;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 16'h0000);
  endtask

  initial begin
    // Reset, then free-running advance from the reset PC.
    cycle(1, 0, 0, 0, 0, 16'h0000);
    cycle(1, 1, 1, 0, 1, 16'h1234);
    idle(5);
    // Branch to 0x0040, second branch during the flush is ignored.
    cycle(0, 0, 0, 0, 1, 16'h0040);
    cycle(0, 0, 0, 0, 1, 16'h0099);
    cycle(0, 0, 1, 0, 0, 16'h0000);
    idle(3);
    // Stall three cycles, then branch + stall + halt together.
    cycle(0, 0, 0, 0, 1, 16'h0010);
    idle(2);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 16'h0000);
    cycle(0, 1, 1, 0, 1, 16'h0100);
    idle(4);
    // Wrap from 0xFFFF to 0x0000.
    cycle(0, 0, 0, 0, 1, 16'hFFFF);
    idle(4);
    // Halt at 0x0020, hold, resume; then halt+resume together.
    cycle(0, 0, 0, 0, 1, 16'h0020);
    idle(2);
    cycle(0, 0, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, 1, 16'h0555);
    cycle(0, 0, 0, 1, 0, 16'h0000);
    idle(2);
    cycle(0, 0, 1, 0, 0, 16'h0000);
    cycle(0, 0, 1, 1, 0, 16'h0000);
    cycle(0, 0, 1, 0, 0, 16'h0000);
    cycle(0, 0, 0, 1, 0, 16'h0000);
    idle(1);
    // Reset mid-flush and mid-halt.
    cycle(0, 0, 0, 0, 1, 16'h0200);
    cycle(1, 0, 0, 0, 0, 16'h0000);
    idle(2);
    cycle(0, 0, 1, 0, 0, 16'h0000);
    cycle(0, 0, 0, 0, 0, 16'h0000);
    cycle(1, 0, 0, 0, 0, 16'h0000);
    idle(2);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      cycle($urandom_range(0, 59) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0,
            tgt);
    end
    idle(1);
    repeat (2) @(negedge clk_pi);
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
